// File: rtl/free_list_mgr_pkg.sv
// Shared types and constants for the packet-buffer free list.
package free_list_mgr_pkg;

    localparam int FL_NUM_BLOCKS = 256;
    localparam int FL_ADDR_W     = $clog2(FL_NUM_BLOCKS);
    localparam int BLOCK_BYTES   = 64;

    // Per-block footer stored in the last bytes of every 64-byte block.
    typedef struct packed {
        logic [FL_ADDR_W-1:0] next_idx;
        logic                 eop;
        logic [6:0]           byte_cnt;
        logic [15:0]          rsvd;
    } footer_t;

    localparam int PAYLOAD_BYTES = BLOCK_BYTES - ($bits(footer_t) / 8);

    typedef enum logic {
        FL_INIT,
        FL_RUN
    } fl_state_t;

endpackage

// File: rtl/free_list_mgr_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        gnt     = '0;
        ptr_nxt = rr_ptr;
        sel     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            sel = PW'((int'(rr_ptr) + i) % N);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                ptr_nxt  = PW'((int'(sel) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/free_list_mgr.sv
// Free block-index pool with round-robin allocation and single-port return.
// Optional double-free detection bitmap: define FL_DOUBLE_FREE_CHECK_EN.
module free_list_mgr
    import free_list_mgr_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int NUM_BLOCKS = FL_NUM_BLOCKS,
    parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] alloc_req_i,
    output logic [NUM_PORTS-1:0] alloc_gnt_o,
    output logic [ADDR_W-1:0]    alloc_block_idx_o,
    input  logic                 free_valid_i,
    input  logic [ADDR_W-1:0]    free_idx_i,
    output logic                 free_ready_o,
    output logic [ADDR_W:0]      free_count_o,
    output logic                 init_done_o,
    output logic                 err_o
);

    // state   | meaning
    // FL_INIT | loading every index into the list, grants and frees blocked
    // FL_RUN  | normal operation, left only by reset

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(NUM_BLOCKS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);

    logic [ADDR_W-1:0]    fifo [NUM_BLOCKS];
    fl_state_t            state;
    logic [ADDR_W-1:0]    head, tail, init_cnt;
    logic [ADDR_W:0]      count;
    logic                 err;
    logic                 run, can_grant, grant, full, free_hit, free_ok, free_acc;
    logic [NUM_PORTS-1:0] rr_gnt;

    assign run       = (state == FL_RUN);
    assign can_grant = run && (count != '0);
    assign full      = (count == FULL_CNT);

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (alloc_req_i & {NUM_PORTS{can_grant}}),
        .advance (grant),
        .gnt     (rr_gnt)
    );

    assign grant    = |rr_gnt;
    assign free_hit = free_valid_i && run;

`ifdef FL_DOUBLE_FREE_CHECK_EN
    logic [NUM_BLOCKS-1:0] in_use;

    assign free_ok = in_use[free_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_use <= '0;
        end else begin
            if (grant)    in_use[fifo[head]] <= 1'b1;
            if (free_acc) in_use[free_idx_i] <= 1'b0;
        end
    end
`else
    assign free_ok = 1'b1;
`endif

    // A full list can still take a free when a grant frees a slot in the same cycle.
    assign free_acc = free_hit && free_ok && !(full && !grant);

    always_ff @(posedge clk) begin
        if (state == FL_INIT) begin
            fifo[init_cnt] <= init_cnt;
        end else if (free_acc) begin
            fifo[tail] <= free_idx_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FL_INIT;
            head     <= '0;
            tail     <= '0;
            init_cnt <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                FL_INIT: begin
                    tail     <= tail + 1'b1;
                    count    <= count + 1'b1;
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_IDX) state <= FL_RUN;
                end
                FL_RUN: begin
                    if (grant)    head <= head + 1'b1;
                    if (free_acc) tail <= tail + 1'b1;
                    count <= count + (ADDR_W+1)'(free_acc) - (ADDR_W+1)'(grant);
                    if (free_hit && !free_acc) err <= 1'b1;
                end
                default: state <= FL_INIT;
            endcase
        end
    end

    assign alloc_gnt_o       = rr_gnt;
    assign alloc_block_idx_o = run ? fifo[head] : '0;
    assign free_ready_o      = run;
    assign init_done_o       = run;
    assign free_count_o      = count;
    assign err_o             = err;

endmodule

// File: tb/tb_free_list_mgr.sv
// Self-checking bench for free_list_mgr: queue-based pool model plus directed literals and random traffic.
module tb_free_list_mgr;

    localparam int NP = 4;
    localparam int NB = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] alloc_req = '0;
    logic [NP-1:0] alloc_gnt;
    logic [AW-1:0] alloc_idx;
    logic          free_valid = 1'b0;
    logic [AW-1:0] free_idx = '0;
    logic          free_ready;
    logic [AW:0]   free_count;
    logic          init_done;
    logic          err;

    always #5 clk = ~clk;

    free_list_mgr #(.NUM_PORTS(NP), .NUM_BLOCKS(NB), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_req_i       (alloc_req),
        .alloc_gnt_o       (alloc_gnt),
        .alloc_block_idx_o (alloc_idx),
        .free_valid_i      (free_valid),
        .free_idx_i        (free_idx),
        .free_ready_o      (free_ready),
        .free_count_o      (free_count),
        .init_done_o       (init_done),
        .err_o             (err)
    );

    typedef struct {
        logic [3:0] g;
        int         idx;
        int         cnt;
        logic       done;
        logic       err;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    // Reference pool: the free list is a plain queue of indices.
    int mq[$];
    int held[$];
    bit m_run;
    int m_init;
    int m_ptr;
    bit m_err;
    bit m_used[NB];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        held.delete();
        m_run  = 1'b0;
        m_init = 0;
        m_ptr  = 0;
        m_err  = 1'b0;
        foreach (m_used[i]) m_used[i] = 1'b0;
    endtask

    // Called at a negedge; drives inputs, checks outputs against the model, then advances one cycle.
    task automatic step(input logic [3:0] req, input bit fv, input int fidx, output obs_t o);
        int  ep;
        int  gi;
        bit  acc;
        alloc_req  = req;
        free_valid = fv;
        free_idx   = 8'(fidx);
        #1;
        ep = -1;
        if (rst_n && m_run && mq.size() > 0) begin
            for (int k = 0; k < NP; k++) begin
                if (ep < 0 && req[(m_ptr + k) % NP]) ep = (m_ptr + k) % NP;
            end
        end
        chk("gnt", 32'(alloc_gnt), (ep < 0) ? 0 : (1 << ep));
        if (ep >= 0) chk("idx", 32'(alloc_idx), mq[0]);
        else if (!m_run) chk("idx_idle", 32'(alloc_idx), 0);
        chk("count", 32'(free_count), m_run ? mq.size() : m_init);
        chk("ready", 32'(free_ready), int'(m_run));
        chk("done", 32'(init_done), int'(m_run));
        chk("err", 32'(err), int'(m_err));
        o.g = alloc_gnt; o.idx = int'(alloc_idx); o.cnt = int'(free_count);
        o.done = init_done; o.err = err;
        @(posedge clk);
        if (rst_n) begin
            if (!m_run) begin
                m_init++;
                if (m_init == NB) begin
                    m_run = 1'b1;
                    for (int i = 0; i < NB; i++) mq.push_back(i);
                end
            end else begin
                acc = fv;
                if (fv && mq.size() == NB && ep < 0) acc = 1'b0;
`ifdef FL_DOUBLE_FREE_CHECK_EN
                if (fv && !m_used[fidx]) acc = 1'b0;
`endif
                if (fv && !acc) m_err = 1'b1;
                if (ep >= 0) begin
                    gi = mq.pop_front();
                    held.push_back(gi);
                    m_used[gi] = 1'b1;
                    m_ptr = (ep + 1) % NP;
                end
                if (acc) begin
                    mq.push_back(fidx);
                    m_used[fidx] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        obs_t o;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 1'b1, 3, o);
            chk("rst_gnt", 32'(o.g), 0);
            chk("rst_err", 32'(o.err), 0);
        end
        rst_n = 1'b1;
    endtask

    task automatic wait_init();
        obs_t o;
        int   n;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            step(4'h0, 1'b0, 0, o);
            if (o.done) break;
            n++;
        end
        chk("init_cycles", 32'(n), NB);
    endtask

    initial begin
        obs_t o;
        int   fidx;
        bit   fv;
        logic [3:0] rq;
        int   j;

        @(negedge clk);
        do_reset();
        wait_init();
        step(4'h0, 1'b0, 0, o);
        chk("count_after_init", 32'(o.cnt), 256);

        for (int k = 0; k < 5; k++) begin
            step(4'hF, 1'b0, 0, o);
            chk("rr_gnt", 32'(o.g), 1 << (k % 4));
            chk("rr_idx", 32'(o.idx), k);
            chk("rr_count", 32'(o.cnt), 256 - k);
        end

        for (int k = 0; k < 5; k++) step(4'h0, 1'b1, k, o);
        step(4'h0, 1'b0, 0, o);
        chk("refill_count", 32'(o.cnt), 256);
`ifndef FL_DOUBLE_FREE_CHECK_EN
        step(4'b0001, 1'b1, 5, o);
        chk("full_swap_gnt", 32'(o.g), 4'b0001);
        step(4'h0, 1'b0, 0, o);
        chk("full_swap_count", 32'(o.cnt), 256);
        chk("full_swap_err", 32'(o.err), 0);
`endif
        step(4'h0, 1'b1, 5, o);
        for (int k = 0; k < 3; k++) begin
            step(4'h0, 1'b0, 0, o);
            chk("ovf_err", 32'(o.err), 1);
            chk("ovf_count", 32'(o.cnt), 256);
        end

        do_reset();
        wait_init();
        for (int k = 0; k < 256; k++) begin
            step(4'b0100, 1'b0, 0, o);
            chk("p2_gnt", 32'(o.g), 4'b0100);
            chk("p2_idx", 32'(o.idx), k);
        end
        step(4'b0100, 1'b0, 0, o);
        chk("empty_gnt", 32'(o.g), 0);
        chk("empty_count", 32'(o.cnt), 0);

        step(4'b0010, 1'b1, 17, o);
        chk("nobypass_gnt", 32'(o.g), 0);
        step(4'b0010, 1'b0, 0, o);
        chk("after_free_gnt", 32'(o.g), 4'b0010);
        chk("after_free_idx", 32'(o.idx), 17);
        chk("after_free_count", 32'(o.cnt), 1);
        step(4'b0010, 1'b0, 0, o);
        chk("reempty_count", 32'(o.cnt), 0);
        chk("reempty_gnt", 32'(o.g), 0);

`ifdef FL_DOUBLE_FREE_CHECK_EN
        do_reset();
        wait_init();
        step(4'b0001, 1'b0, 0, o);
        chk("df_alloc_idx", 32'(o.idx), 0);
        step(4'h0, 1'b1, 9, o);
        step(4'h0, 1'b0, 0, o);
        chk("df_err", 32'(o.err), 1);
        chk("df_count", 32'(o.cnt), 255);
        step(4'h0, 1'b1, 0, o);
        step(4'h0, 1'b0, 0, o);
        chk("df_ok_count", 32'(o.cnt), 256);
`endif

        do_reset();
        wait_init();
        for (int k = 0; k < 3000; k++) begin
            rq = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(0, 15));
            fv = ($urandom_range(0, 99) < 45);
            fidx = 0;
            if (fv) begin
                if (held.size() > 0 && $urandom_range(0, 9) < 8) begin
                    j = int'($urandom_range(0, held.size() - 1));
                    fidx = held[j];
                    held.delete(j);
                end else begin
                    fidx = int'($urandom_range(0, NB - 1));
                end
            end
            step(rq, fv, fidx, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
